nano_mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the NanoCPU's single-port 256 x 16 memory. Port 0 serves the NanoCPU and port 1 serves a host/loader or DMA agent. The block grants one requester at a time, drives the memory's `address`/`dataW`/`ce`/`we` for exactly one access cycle, then returns an acknowledge with registered read data. It sits between the requesters and the memory array, replacing the direct CPU-to-memory connection.

---
 rtl/nano_mem_pkg.sv | 23 ++
 rtl/nano_rr_arb2.sv | 39 +++
 rtl/nano_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_nano_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_mem_pkg.sv
// nano_mem_pkg: shared definitions for the NanoCPU memory arbiter.
//   - default address/data widths and memory depth of the 256 x 16 array
//   - arb_state_t : sequencer state (IDLE, ACCESS, RESP)
//   - mem_req_t   : one latched access request {we, addr, wdata}
package nano_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int MEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/nano_rr_arb2.sv
// nano_rr_arb2: combinational two-way grant.
//   req[1:0]   : raw request vector (bit n = port n)
//   mask[1:0]  : ports excluded from this evaluation
//   last       : last-granted port (round-robin build only)
//   gnt_valid  : some unmasked port is requesting
//   gnt_idx    : index of the winning port
// Configuration macro NANO_MEMARB_FIXED_PRIO_EN: when defined, port 0 wins
// every tie and the last input does not exist; otherwise ties go to the port
// that was not granted last.
module nano_rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
`ifndef NANO_MEMARB_FIXED_PRIO_EN
  input  logic       last,
`endif
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] eff;

  assign eff = req & ~mask;

  always_comb begin
    gnt_valid = |eff;
    gnt_idx   = 1'b0;
    if (eff == 2'b11) begin
`ifdef NANO_MEMARB_FIXED_PRIO_EN
      gnt_idx = 1'b0;
`else
      gnt_idx = ~last;
`endif
    end else begin
      // Single requester (or none): bit 1 alone selects port 1.
      gnt_idx = eff[1];
    end
  end

endmodule

// File: rtl/nano_mem_arbiter.sv
// nano_mem_arbiter: two-requester arbiter and access sequencer for the
// NanoCPU single-port memory. Port 0 = CPU, port 1 = host/DMA.
//   ck, rst                       : clock, async active-high reset
//   req/we/addr/wdata 0,1         : request side (held until matching ack)
//   ack0/ack1, rdata0/rdata1      : one-cycle ack, registered read data
//   address, dataW, ce, we, dataR : memory side (dataR combinational)
// Sequence per access: IDLE/RESP grant -> ACCESS (memory driven one cycle)
// -> RESP (ack). A grant made in RESP gives back-to-back accesses.
// Handshake: a requester raises req with stable we/addr/wdata and keeps it
// high until it sees its ack; req still high after the ack cycle is a new
// request.
// Configuration macro NANO_MEMARB_FIXED_PRIO_EN selects fixed priority
// (port 0) instead of round-robin and removes the last-grant register.
module nano_mem_arbiter
  import nano_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataW,
  input  logic [DATA_W-1:0] dataR,
  output logic              ce,
  output logic              we
);

  arb_state_t        state;
  logic              win;        // port owning the access in flight
  logic [1:0]        mask;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
`ifndef NANO_MEMARB_FIXED_PRIO_EN
  logic              last;
`endif

  // In RESP the winner's req is still high from the access just finished,
  // so it is hidden from this round.
  assign mask = (state == RESP) ? (win ? 2'b10 : 2'b01) : 2'b00;

  nano_rr_arb2 u_arb (
    .req       ({req1, req0}),
    .mask      (mask),
`ifndef NANO_MEMARB_FIXED_PRIO_EN
    .last      (last),
`endif
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign sel_we    = gnt_idx ? we1    : we0;
  assign sel_addr  = gnt_idx ? addr1  : addr0;
  assign sel_wdata = gnt_idx ? wdata1 : wdata0;

  // The address/dataW/we registers double as the request latch: they are
  // loaded at grant time and drive the memory during ACCESS.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win     <= 1'b0;
      ce      <= 1'b0;
      we      <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      address <= '0;
      dataW   <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
`ifndef NANO_MEMARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ACCESS: begin
          ce <= 1'b0;
          we <= 1'b0;
          if (!we) begin
            if (win) rdata1 <= dataR;
            else     rdata0 <= dataR;
          end
          ack0  <= ~win;
          ack1  <= win;
          state <= RESP;
        end
        default: begin
          // IDLE and RESP share the grant path.
          if (gnt_valid) begin
            win     <= gnt_idx;
            ce      <= 1'b1;
            we      <= sel_we;
            address <= sel_addr;
            dataW   <= sel_wdata;
`ifndef NANO_MEMARB_FIXED_PRIO_EN
            last    <= gnt_idx;
`endif
            state   <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// tb_nano_mem_arbiter: table-driven bench for nano_mem_arbiter with a
// behavioural 256 x 16 memory, plus sequences for round-robin streaming,
// reset during ACCESS and a Fibonacci program on port 0.
module tb_nano_mem_arbiter;
  import nano_mem_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, ce, we;
  logic [15:0] rdata0, rdata1, dataW, dataR;
  logic [7:0]  address;

  always #5 ck = ~ck;

  nano_mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .ck(ck), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .address(address), .dataW(dataW), .dataR(dataR), .ce(ce), .we(we)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:255];
  logic        mem_ready = 1'b0;

  assign dataR = mem[address];

  always @(posedge ck) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
      mem[30]   <= 16'h000A;
      mem[20]   <= 16'h2020;
      mem_ready <= 1'b1;
    end else if (ce && we) begin
      mem[address] <= dataW;
    end
  end

  // ---------------- request stability checker ----------------
  mem_req_t p0_q, p1_q;
  logic     p0_req_q = 1'b0, p1_req_q = 1'b0, p0_ack_q = 1'b0, p1_ack_q = 1'b0;

  always @(posedge ck) begin
    if (!rst && req0 && p0_req_q && !p0_ack_q)
      assert (p0_q == {we0, addr0, wdata0}) else $error("port0 request changed before ack");
    if (!rst && req1 && p1_req_q && !p1_ack_q)
      assert (p1_q == {we1, addr1, wdata1}) else $error("port1 request changed before ack");
    p0_req_q <= req0;
    p1_req_q <= req1;
    p0_ack_q <= ack0;
    p1_ack_q <= ack1;
    p0_q     <= {we0, addr0, wdata0};
    p1_q     <= {we1, addr1, wdata1};
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        ce;
    logic        we;
    logic [7:0]  address;
    logic [15:0] dataw;
    logic        ack0;
    logic        ack1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
  } obs_t;

  typedef struct {
    logic        r0, w0;
    logic [7:0]  a0;
    logic [15:0] d0;
    logic        r1, w1;
    logic [7:0]  a1;
    logic [15:0] d1;
    obs_t        exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  function automatic obs_t observe();
    obs_t o;
    o.ce = ce; o.we = we; o.address = address; o.dataw = dataW;
    o.ack0 = ack0; o.ack1 = ack1; o.rdata0 = rdata0; o.rdata1 = rdata1;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = observe();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ce=%b we=%b addr=%h dataW=%h ack0=%b ack1=%b rd0=%h rd1=%h, need ce=%b we=%b addr=%h dataW=%h ack0=%b ack1=%b rd0=%h rd1=%h",
               name, act.ce, act.we, act.address, act.dataw, act.ack0, act.ack1, act.rdata0, act.rdata1,
               exp.ce, exp.we, exp.address, exp.dataw, exp.ack0, exp.ack1, exp.rdata0, exp.rdata1);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, need %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                              input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                              input logic ece, input logic ewe, input logic [7:0] eaddr, input logic [15:0] edw,
                              input logic ea0, input logic ea1, input logic [15:0] er0, input logic [15:0] er1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.exp.ce = ece; v.exp.we = ewe; v.exp.address = eaddr; v.exp.dataw = edw;
    v.exp.ack0 = ea0; v.exp.ack1 = ea1; v.exp.rdata0 = er0; v.exp.rdata1 = er1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  // One port-0 access from IDLE; the ack must arrive exactly 2 cycles later.
  task automatic cpu_access(input logic w, input logic [7:0] a, input logic [15:0] wd,
                            output logic [15:0] rd);
    int cyc;
    @(negedge ck);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd;
    cyc = 0;
    do begin
      @(negedge ck);
      cyc++;
    end while (!ack0 && cyc < 8);
    check_val("cpu_ack_latency", 32'(cyc), 32'd2);
    rd = rdata0;
    if (!w) check_val("cpu_rdata", {16'h0, rd}, {16'h0, mem[a]});
    req0 = 1'b0; we0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  vec_t        vq[$];
  obs_t        zero_obs;
  int          ack_port[$];
  int          ack_cyc[$];
  logic [15:0] x, y, dummy;
  logic [15:0] fib_exp[10];

  initial begin
    zero_obs = '0;

    // Reset state.
    @(negedge ck);
    check_obs("reset_state", zero_obs);
    @(negedge ck);
    @(negedge ck);
    rst = 1'b0;

    // Read 30 on port 0, write 0x1234 to 15 on port 1, then a tie
    // (port 0 read 30 / port 1 read 16) after port 1 was granted last.
    //               r0 w0 a0     d0         r1 w1 a1     d1          ce we addr   dataW      a0 a1 rd0       rd1
    vq.push_back(mk(1, 0, 8'd30, 16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd0,  16'h0000, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 0, 8'd30, 16'h0,     0, 0, 8'd0,  16'h0,      1, 0, 8'd30, 16'h0000, 0, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 8'd30, 16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd30, 16'h0000, 1, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd30, 16'h0000, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     1, 1, 8'd15, 16'h1234,   0, 0, 8'd30, 16'h0000, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     1, 1, 8'd15, 16'h1234,   1, 1, 8'd15, 16'h1234, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd15, 16'h1234, 0, 1, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd15, 16'h1234, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(1, 0, 8'd30, 16'h0,     1, 0, 8'd16, 16'h0,      0, 0, 8'd15, 16'h1234, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(1, 0, 8'd30, 16'h0,     1, 0, 8'd16, 16'h0,      1, 0, 8'd30, 16'h0000, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd30, 16'h0,     1, 0, 8'd16, 16'h0,      0, 0, 8'd30, 16'h0000, 1, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     1, 0, 8'd16, 16'h0,      1, 0, 8'd16, 16'h0000, 0, 0, 16'h000A, 16'h0000));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd16, 16'h0000, 0, 1, 16'h000A, 16'h0010));
    vq.push_back(mk(0, 0, 8'd0,  16'h0,     0, 0, 8'd0,  16'h0,      0, 0, 8'd16, 16'h0000, 0, 0, 16'h000A, 16'h0010));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge ck);
      drive(vq[i]);
      check_obs($sformatf("vec%0d", i), vq[i].exp);
    end
    check_val("mem15_written", {16'h0, mem[15]}, 32'h1234);

    // Both ports hold req for 6 accesses: grants alternate starting with
    // port 0 (port 1 was granted last), one ack every 2 cycles.
    @(negedge ck);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd40;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd41;
    for (int c = 0; c < 40 && ack_port.size() < 6; c++) begin
      @(negedge ck);
      if (ack0 || ack1) begin
        ack_port.push_back(ack1 ? 1 : 0);
        ack_cyc.push_back(c);
        exp_q.push_back(ack1 ? 16'h0029 : 16'h0028);
        check_val("rr_rdata", {16'h0, ack1 ? rdata1 : rdata0}, {16'h0, exp_q.pop_front()});
      end
      if (ack_port.size() == 6) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check_val("rr_ack_count", 32'(ack_port.size()), 32'd6);
    for (int i = 0; i < ack_port.size(); i++) begin
      check_val($sformatf("rr_grant%0d", i), 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) check_val($sformatf("rr_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
    end

    // Reset while port 1's write to 20 is in ACCESS: nothing commits,
    // outputs return to reset values at once, no ack follows.
    @(negedge ck);
    @(negedge ck);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd20; wdata1 = 16'hBEEF;
    @(negedge ck);
    check_val("rst_access_started", {30'h0, ce, we}, 32'h3);
    rst = 1'b1;
    #1;
    check_obs("rst_mid_access", zero_obs);
    @(negedge ck);
    req1 = 1'b0; we1 = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    begin
      int acks = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge ck);
        if (ack0 || ack1) acks++;
      end
      check_val("rst_no_ack", 32'(acks), 32'd0);
    end
    check_val("rst_mem20_kept", {16'h0, mem[20]}, 32'h2020);

    // Fibonacci (10 terms at 15..24) through port 0, port 1 idle.
    fib_exp = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55};
    cpu_access(1'b1, 8'd15, 16'd1, dummy);
    cpu_access(1'b1, 8'd16, 16'd1, dummy);
    for (int i = 17; i <= 24; i++) begin
      cpu_access(1'b0, 8'(i - 2), 16'h0, x);
      cpu_access(1'b0, 8'(i - 1), 16'h0, y);
      cpu_access(1'b1, 8'(i), x + y, dummy);
    end
    for (int i = 0; i < 10; i++)
      check_val($sformatf("fib_mem%0d", 15 + i), {16'h0, mem[15 + i]}, {16'h0, fib_exp[i]});

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
